// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding
// and counter sizing helper.
package serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [1:0] state_t;

    // Bit counter must address WIDTH positions; a 1-bit adder still needs one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder_design.sv
// Single-bit full adder shared by the serial datapath.
module full_adder_design (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic S,
    output logic cout
);

    assign S    = A ^ B ^ cin;
    assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first,
// producing {cout,sum} = a + b + cin after WIDTH RUN cycles.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, psum_reg, sum_reg;
    logic [WIDTH-1:0] psum_next;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg, cout_reg;
    logic             fa_s, fa_cout;
    logic             last_bit;

    full_adder_design u_fa (
        .A    (a_sh_reg[0]),
        .B    (b_sh_reg[0]),
        .cin  (carry_reg),
        .S    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    generate
        if (WIDTH == 1) begin : g_psum_w1
            assign psum_next = fa_s;
        end else begin : g_psum_wn
            assign psum_next = {fa_s, psum_reg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (state_reg == ST_RUN) && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                a_sh_reg  <= a;
                b_sh_reg  <= b;
                carry_reg <= cin;
                cnt_reg   <= '0;
            end else if (state_reg == ST_RUN) begin
                a_sh_reg  <= a_sh_reg >> 1;
                b_sh_reg  <= b_sh_reg >> 1;
                psum_reg  <= psum_next;
                carry_reg <= fa_cout;
                cnt_reg   <= cnt_reg + CW'(1);
            end
            // Visible result only changes when the final bit is produced.
            if (last_bit) begin
                sum_reg  <= psum_next;
                cout_reg <= fa_cout;
            end
        end
    end

    always_comb begin
        busy = (state_reg == ST_RUN);
        done = (state_reg == ST_DONE);
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] last8    = '0;
    logic [1:0] last1    = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl8[8];
    vec_t tbl1[8];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cur_done(input bit w1);
        return w1 ? done1 : done8;
    endfunction

    function automatic logic cur_busy(input bit w1);
        return w1 ? busy1 : busy8;
    endfunction

    function automatic logic [8:0] cur_res(input bit w1);
        return w1 ? {7'b0, cout1, sum1} : {cout8, sum8};
    endfunction

    task automatic drive(input bit w1, input logic st, input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        if (w1) begin
            start1 = st; a1 = ia[0]; b1 = ib[0]; cin1 = ic;
        end else begin
            start8 = st; a8 = ia; b8 = ib; cin8 = ic;
        end
    endtask

    // One complete operation: accept, watch RUN, check latency/busy/hold/result.
    task automatic do_op(input bit w1, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [8:0] exp, input int disturb_at, input string tag);
        int         lat, busy_cnt, w;
        bit         hold_ok;
        logic [8:0] prev;
        w    = w1 ? 1 : 8;
        prev = w1 ? {7'b0, last1} : last8;
        @(negedge clk);
        drive(w1, 1'b1, ia, ib, ic);
        @(posedge clk);
        @(negedge clk);
        drive(w1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        lat = 0; busy_cnt = 0; hold_ok = 1'b1;
        while (!cur_done(w1) && lat < 40) begin
            if (cur_busy(w1)) busy_cnt++;
            if (cur_res(w1) !== prev) hold_ok = 1'b0;
            if (lat == disturb_at) drive(w1, 1'b1, 8'h11, 8'h11, 1'b1);
            else drive(w1, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        drive(w1, 1'b0, ia, ib, ic);
        check({tag, "_done"}, 32'(cur_done(w1)), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(w));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(w));
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_result"}, 32'(cur_res(w1)), 32'(exp));
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'b0, cur_done(w1), cur_busy(w1)}, 32'd0);
        if (w1) last1 = exp[1:0];
        else last8 = exp;
    endtask

    initial begin
        int         ndone, first_pos, second_pos, waited;
        logic [8:0] exp;
        logic [7:0] ra, rb;
        logic       rc;

        tbl8[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
        tbl8[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tbl8[2] = '{8'h7F, 8'h01, 1'b0, 9'h080};
        tbl8[3] = '{8'hA5, 8'h5A, 1'b1, 9'h100};
        tbl8[4] = '{8'h12, 8'h34, 1'b1, 9'h047};
        tbl8[5] = '{8'h80, 8'h80, 1'b0, 9'h100};
        tbl8[6] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        tbl8[7] = '{8'h55, 8'h2A, 1'b0, 9'h07F};
        tbl1[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
        tbl1[1] = '{8'h00, 8'h00, 1'b1, 9'h001};
        tbl1[2] = '{8'h00, 8'h01, 1'b0, 9'h001};
        tbl1[3] = '{8'h00, 8'h01, 1'b1, 9'h002};
        tbl1[4] = '{8'h01, 8'h00, 1'b0, 9'h001};
        tbl1[5] = '{8'h01, 8'h00, 1'b1, 9'h002};
        tbl1[6] = '{8'h01, 8'h01, 1'b0, 9'h002};
        tbl1[7] = '{8'h01, 8'h01, 1'b1, 9'h003};

        rst = 1'b1;
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        drive(1'b1, 1'b1, 8'h01, 8'h01, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_w8", {22'b0, busy8, done8, cout8, sum8}, 32'd0);
        check("reset_w1", {28'b0, busy1, done1, cout1, sum1}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, tbl8[i].a, tbl8[i].b, tbl8[i].cin, tbl8[i].exp, -1, $sformatf("w8_vec%0d", i));
            $display("w8 vec%0d a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h", i,
                     tbl8[i].a, tbl8[i].b, tbl8[i].cin, cout8, sum8);
        end

        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, tbl1[i].a, tbl1[i].b, tbl1[i].cin, tbl1[i].exp, -1, $sformatf("w1_vec%0d", i));
            $display("w1 vec%0d a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", i,
                     tbl1[i].a[0], tbl1[i].b[0], tbl1[i].cin, cout1, sum1);
        end

        // Start pulse with new operands in the middle of a run must be ignored.
        do_op(1'b0, 8'h20, 8'h03, 1'b0, 9'h023, 3, "w8_midrun_start");
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check("w8_midrun_no_second_op", 32'(ndone), 32'd0);
        $display("midrun start: cout=%0d sum=%02h", cout8, sum8);

        // Reset at RUN cycle 4 discards the operation.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h3C, 8'h4B, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("w8_midrun_reset", {22'b0, busy8, done8, cout8, sum8}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        last8 = '0;
        last1 = '0;
        do_op(1'b0, 8'h0F, 8'h01, 1'b0, 9'h010, -1, "w8_after_reset");
        $display("after reset: cout=%0d sum=%02h", cout8, sum8);

        // Held start: one operation per IDLE cycle, period WIDTH+2.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        ndone = 0; first_pos = -1; second_pos = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) begin
                if (ndone == 0) first_pos = i;
                if (ndone == 1) second_pos = i;
                ndone++;
                check("w8_b2b_result", 32'({cout8, sum8}), 32'h046);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("w8_b2b_count", 32'(ndone), 32'd3);
        check("w8_b2b_period", 32'(second_pos - first_pos), 32'd10);
        $display("back-to-back: dones=%0d period=%0d", ndone, second_pos - first_pos);
        waited = 0;
        while ((busy8 || done8) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("w8_b2b_drain", {30'b0, busy8, done8}, 32'd0);
        last8 = 9'h046;

        for (int i = 0; i < 30; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            do_op(1'b0, ra, rb, rc, exp, -1, $sformatf("w8_rand%0d", i));
            $display("w8 rand%0d a=%02h b=%02h cin=%0d -> cout=%0d sum=%02h", i, ra, rb, rc, cout8, sum8);
        end
        for (int i = 0; i < 8; i++) begin
            ra  = 8'($urandom_range(0, 1));
            rb  = 8'($urandom_range(0, 1));
            rc  = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            do_op(1'b1, ra, rb, rc, exp, -1, $sformatf("w1_rand%0d", i));
            $display("w1 rand%0d a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", i, ra[0], rb[0], rc, cout1, sum1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
